// File: rtl/prbs31_pkg.sv
// ---------------------------------------------------------------------------
// prbs31_pkg
// Shared definitions for the PRBS31 (x^31 + x^28 + 1) generator and checker,
// so both ends of the link agree on one polynomial.
//   PRBS_LEN        : LFSR length in bits
//   TAP_A / TAP_B   : state bits XORed to form the next sequence bit
//   prbs_state_e    : checker FSM states (SEARCH=0, VERIFY=1, LOCKED=2)
//   prbs31_next_bit : next sequence bit predicted from an LFSR state
// ---------------------------------------------------------------------------
package prbs31_pkg;

  localparam int PRBS_LEN = 31;
  localparam int TAP_A    = 30;
  localparam int TAP_B    = 27;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // s[0] holds the newest bit, so s[30] is b[n-31] and s[27] is b[n-28].
  function automatic logic prbs31_next_bit(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// ---------------------------------------------------------------------------
// prbs31_checker_if
// Bit-stream input and statistics output bundle of the PRBS31 checker.
//   bit_valid / bit_in : received serial bit and its qualifier
//   clear              : synchronous clear of err_count and bit_count
//   locked / state     : FSM status
//   err_pulse          : one-cycle strobe per mismatching bit while locked
//   err_count          : saturating error counter (ERR_W bits)
//   bit_count          : saturating compared-bit counter (32 bits)
// master = stream source / statistics consumer, slave = checker.
// ---------------------------------------------------------------------------
interface prbs31_checker_if #(
  parameter int ERR_W = 16
) ();

  logic             bit_valid;
  logic             bit_in;
  logic             clear;
  logic             locked;
  logic [1:0]       state;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [31:0]      bit_count;

  modport master (
    output bit_valid, bit_in, clear,
    input  locked, state, err_pulse, err_count, bit_count
  );

  modport slave (
    input  bit_valid, bit_in, clear,
    output locked, state, err_pulse, err_count, bit_count
  );

endinterface

// File: rtl/prbs31_err_window.sv
// ---------------------------------------------------------------------------
// prbs31_err_window
// Block-window loss-of-lock detector. Counts compared bits and errors in
// consecutive WIN_BITS-bit windows; raises loss combinationally on the bit
// that brings the window error count to LOSS_THRESH.
//   clk, rst_n : clock, asynchronous active-low reset
//   advance    : one compared bit this cycle
//   err        : that bit mismatched (only meaningful with advance)
//   restart    : hold the window at its start (checker not locked)
//   loss       : threshold reached by the current bit
// ---------------------------------------------------------------------------
module prbs31_err_window #(
  parameter int WIN_BITS    = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic err,
  input  logic restart,
  output logic loss
);

  localparam int POS_W = $clog2(WIN_BITS + 1);
  localparam int CNT_W = $clog2(LOSS_THRESH + 1);

  logic [POS_W-1:0] r_pos;
  logic [CNT_W-1:0] r_errs;
  logic             w_win_end;

  // Loss must be visible on the same edge that registers the final error.
  assign loss      = advance && err && (r_errs == CNT_W'(LOSS_THRESH - 1));
  assign w_win_end = (r_pos == POS_W'(WIN_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= '0;
      r_errs <= '0;
    end else if (restart || (advance && (loss || w_win_end))) begin
      r_pos  <= '0;
      r_errs <= '0;
    end else if (advance) begin
      r_pos  <= r_pos + POS_W'(1);
      r_errs <= r_errs + CNT_W'(err);
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// ---------------------------------------------------------------------------
// prbs31_checker
// Self-synchronising PRBS31 receiver. SEARCH loads 31 received bits into the
// LFSR, VERIFY checks LOCK_BITS predicted bits, LOCKED free-runs the LFSR and
// counts errors and compared bits. Loss of lock is decided by
// prbs31_err_window.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : prbs31_checker_if.slave (stream in, status/statistics out)
// ---------------------------------------------------------------------------
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_BITS   = 32,
  parameter int WIN_BITS    = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prbs31_checker_if.slave        bus
);

  localparam int VCNT_W = $clog2(LOCK_BITS + 1);

  prbs_state_e          r_state, w_state_next;
  logic [PRBS_LEN-1:0]  r_lfsr, w_lfsr_next;
  logic [4:0]           r_fill, w_fill_next;
  logic [VCNT_W-1:0]    r_vcnt, w_vcnt_next;
  logic [ERR_W-1:0]     r_err_count, w_err_count_next;
  logic [31:0]          r_bit_count, w_bit_count_next;
  logic                 r_err_pulse, w_err_pulse_next;
  logic                 r_locked;

  logic                 w_pred;
  logic                 w_mismatch;
  logic [PRBS_LEN-1:0]  w_shift_rx;
  logic [PRBS_LEN-1:0]  w_shift_pred;
  logic                 w_win_advance;
  logic                 w_win_err;
  logic                 w_win_restart;
  logic                 w_loss;

  assign w_pred        = prbs31_next_bit(r_lfsr);
  assign w_mismatch    = bus.bit_in ^ w_pred;
  assign w_shift_rx    = {r_lfsr[PRBS_LEN-2:0], bus.bit_in};
  assign w_shift_pred  = {r_lfsr[PRBS_LEN-2:0], w_pred};
  assign w_win_advance = bus.bit_valid && (r_state == LOCKED);
  assign w_win_err     = w_win_advance && w_mismatch;
  assign w_win_restart = (r_state != LOCKED);

  prbs31_err_window #(
    .WIN_BITS    (WIN_BITS),
    .LOSS_THRESH (LOSS_THRESH)
  ) u_err_window (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (w_win_advance),
    .err     (w_win_err),
    .restart (w_win_restart),
    .loss    (w_loss)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_lfsr_next      = r_lfsr;
    w_fill_next      = r_fill;
    w_vcnt_next      = r_vcnt;
    w_err_count_next = r_err_count;
    w_bit_count_next = r_bit_count;
    w_err_pulse_next = 1'b0;

    if (bus.bit_valid) begin
      unique case (r_state)
        SEARCH: begin
          w_lfsr_next = w_shift_rx;
          if (r_fill == 5'(PRBS_LEN - 1)) begin
            w_fill_next = '0;
            // An all-zero capture is the LFSR lock-up state: refill instead.
            if (w_shift_rx != '0) begin
              w_state_next = VERIFY;
              w_vcnt_next  = '0;
            end
          end else begin
            w_fill_next = r_fill + 5'd1;
          end
        end
        VERIFY: begin
          w_lfsr_next = w_shift_pred;
          if (w_mismatch) begin
            w_state_next = SEARCH;
            w_fill_next  = '0;
          end else if (r_vcnt == VCNT_W'(LOCK_BITS - 1)) begin
            w_state_next = LOCKED;
            w_vcnt_next  = '0;
          end else begin
            w_vcnt_next = r_vcnt + VCNT_W'(1);
          end
        end
        LOCKED: begin
          // Free-running: received bits never enter the LFSR here.
          w_lfsr_next = w_shift_pred;
          if (~&r_bit_count) begin
            w_bit_count_next = r_bit_count + 32'd1;
          end
          if (w_mismatch) begin
            w_err_pulse_next = 1'b1;
            if (~&r_err_count) begin
              w_err_count_next = r_err_count + ERR_W'(1);
            end
          end
          if (w_loss) begin
            w_state_next = SEARCH;
            w_fill_next  = '0;
          end
        end
        default: begin
          w_state_next = SEARCH;
          w_fill_next  = '0;
        end
      endcase
    end

    // Clear takes priority over a same-cycle increment.
    if (bus.clear) begin
      w_err_count_next = '0;
      w_bit_count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= '0;
      r_fill      <= '0;
      r_vcnt      <= '0;
      r_err_count <= '0;
      r_bit_count <= '0;
      r_err_pulse <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_lfsr      <= w_lfsr_next;
      r_fill      <= w_fill_next;
      r_vcnt      <= w_vcnt_next;
      r_err_count <= w_err_count_next;
      r_bit_count <= w_bit_count_next;
      r_err_pulse <= w_err_pulse_next;
      r_locked    <= (w_state_next == LOCKED);
    end
  end

  assign bus.state     = r_state;
  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_count = r_err_count;
  assign bus.bit_count = r_bit_count;

endmodule

// File: tb/tb_prbs31_checker.sv
// ---------------------------------------------------------------------------
// tb_prbs31_checker
// Drives two checker instances (default parameters, and ERR_W=4 /
// LOSS_THRESH=64) from a recurrence-based PRBS31 source and compares every
// cycle against a queue-based reference model, plus directed checks.
// ---------------------------------------------------------------------------
module tb_prbs31_checker;

  localparam int LOCK_BITS = 32;
  localparam int WIN_BITS  = 64;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;

  prbs31_checker_if #(.ERR_W(16)) ifa ();
  prbs31_checker_if #(.ERR_W(4))  ifb ();

  prbs31_checker #(
    .LOCK_BITS(LOCK_BITS), .WIN_BITS(WIN_BITS), .LOSS_THRESH(8), .ERR_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(ifa.slave)
  );

  prbs31_checker #(
    .LOCK_BITS(LOCK_BITS), .WIN_BITS(WIN_BITS), .LOSS_THRESH(64), .ERR_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int sel      = 0;

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- PRBS31 source: b[n] = b[n-31] ^ b[n-28] ----------------
  bit g_hist[$];

  task automatic gen_reset();
    g_hist.delete();
    for (int i = 0; i < 31; i++) g_hist.push_back(1'b1);
  endtask

  task automatic gen_next(output bit b);
    b = g_hist[0] ^ g_hist[3];
    void'(g_hist.pop_front());
    g_hist.push_back(b);
  endtask

  // ---------------- reference model ----------------
  int              m_state;
  bit              m_hist[$];
  int              m_vcnt, m_wpos, m_werr, m_thresh;
  longint unsigned m_errs, m_bits, m_err_max;
  bit              m_pulse;

  task automatic model_reset();
    m_state = 0; m_hist.delete(); m_vcnt = 0; m_wpos = 0; m_werr = 0;
    m_errs = 0; m_bits = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit p;
    bit nz;
    m_pulse = 0;
    if (v) begin
      case (m_state)
        0: begin
          m_hist.push_back(b);
          if (m_hist.size() == 31) begin
            nz = 0;
            foreach (m_hist[i]) nz |= m_hist[i];
            if (nz) begin m_state = 1; m_vcnt = 0; end
            else m_hist.delete();
          end
        end
        1: begin
          p = m_hist[0] ^ m_hist[3];
          void'(m_hist.pop_front());
          m_hist.push_back(p);
          if (b != p) begin
            m_state = 0; m_hist.delete();
          end else begin
            m_vcnt++;
            if (m_vcnt == LOCK_BITS) begin m_state = 2; m_wpos = 0; m_werr = 0; end
          end
        end
        default: begin
          p = m_hist[0] ^ m_hist[3];
          void'(m_hist.pop_front());
          m_hist.push_back(p);
          if (m_bits < 64'hFFFF_FFFF) m_bits++;
          m_wpos++;
          if (b != p) begin
            m_pulse = 1;
            if (m_errs < m_err_max) m_errs++;
            m_werr++;
          end
          if (m_werr == m_thresh) begin
            m_state = 0; m_hist.delete();
          end else if (m_wpos == WIN_BITS) begin
            m_wpos = 0; m_werr = 0;
          end
        end
      endcase
    end
    if (clr) begin m_errs = 0; m_bits = 0; end
  endtask

  // ---------------- DUT access ----------------
  task automatic get_obs(output longint unsigned st, output longint unsigned lk,
                         output longint unsigned ep, output longint unsigned ec,
                         output longint unsigned bc);
    if (sel == 0) begin
      st = ifa.state; lk = ifa.locked; ep = ifa.err_pulse;
      ec = ifa.err_count; bc = ifa.bit_count;
    end else begin
      st = ifb.state; lk = ifb.locked; ep = ifb.err_pulse;
      ec = ifb.err_count; bc = ifb.bit_count;
    end
  endtask

  task automatic compare_model();
    longint unsigned st, lk, ep, ec, bc;
    get_obs(st, lk, ep, ec, bc);
    check("state",     st, longint'(m_state));
    check("locked",    lk, longint'(m_state == 2));
    check("err_pulse", ep, longint'(m_pulse));
    check("err_count", ec, m_errs);
    check("bit_count", bc, m_bits);
  endtask

  task automatic step(input bit v, input bit b, input bit clr);
    if (sel == 0) begin
      ifa.bit_valid = v; ifa.bit_in = b; ifa.clear = clr;
      ifb.bit_valid = 0; ifb.bit_in = 0; ifb.clear = 0;
    end else begin
      ifb.bit_valid = v; ifb.bit_in = b; ifb.clear = clr;
      ifa.bit_valid = 0; ifa.bit_in = 0; ifa.clear = 0;
    end
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    compare_model();
  endtask

  // Valid cycles take the next source bit, optionally inverted.
  task automatic send(input bit v, input bit flip, input bit clr);
    bit b;
    b = 0;
    if (v) begin
      gen_next(b);
      b ^= flip;
    end
    step(v, b, clr);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    longint unsigned st, lk, ep, ec, bc;
    int  pulses;
    int  last;
    int  rate;
    int  cycles;
    bit  fm[WIN_BITS];
    bit  pre_last_lk;
    bit  saw_locked;

    sel = 0;
    rst_n_a = 0; rst_n_b = 0;
    ifa.bit_valid = 0; ifa.bit_in = 0; ifa.clear = 0;
    ifb.bit_valid = 0; ifb.bit_in = 0; ifb.clear = 0;
    gen_reset();
    model_reset();
    m_thresh = 8; m_err_max = 64'hFFFF;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    get_obs(st, lk, ep, ec, bc);
    check("rst_state", st, 0); check("rst_locked", lk, 0);
    check("rst_err_pulse", ep, 0); check("rst_err_count", ec, 0);
    check("rst_bit_count", bc, 0);
    rst_n_a = 1;
    $display("TXN reset state=%0d locked=%0d", st, lk);

    // Clean lock
    repeat (31) send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("verify_after_31", st, 1);
    repeat (31) send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("unlocked_at_62", lk, 0);
    send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("locked_at_63", lk, 1);
    repeat (1000) send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("clean_err_count", ec, 0);
    check("clean_bit_count", bc, 1000);
    $display("TXN clean_lock locked=%0d err_count=%0d bit_count=%0d", lk, ec, bc);

    // Single error on the 100th bit
    pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      send(1, i == 100, 0);
      get_obs(st, lk, ep, ec, bc);
      if (ep != 0) pulses++;
    end
    check("single_pulses", pulses, 1);
    check("single_err_count", ec, 1);
    check("single_locked", lk, 1);
    $display("TXN single_error pulses=%0d err_count=%0d locked=%0d", pulses, ec, lk);

    // Burst of 8 errors inside one window
    send(1, 0, 1);
    get_obs(st, lk, ep, ec, bc);
    check("clear_err_count", ec, 0);
    for (int i = 0; i < WIN_BITS && m_wpos != 0; i++) send(1, 0, 0);
    foreach (fm[i]) fm[i] = 0;
    pulses = 0;
    while (pulses < 8) begin
      int k;
      k = $urandom_range(WIN_BITS - 1);
      if (!fm[k]) begin fm[k] = 1; pulses++; end
    end
    last = 0;
    foreach (fm[i]) if (fm[i]) last = i;
    pulses = 0;
    pre_last_lk = 0;
    for (int i = 0; i <= last; i++) begin
      if (i == last) begin
        get_obs(st, lk, ep, ec, bc);
        pre_last_lk = lk[0];
      end
      send(1, fm[i], 0);
      get_obs(st, lk, ep, ec, bc);
      if (ep != 0) pulses++;
    end
    check("burst_locked_before_8th", pre_last_lk, 1);
    check("burst_pulses", pulses, 8);
    check("burst_loss", lk, 0);
    check("burst_err_count", ec, 8);
    repeat (62) send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("burst_relock_62", lk, 0);
    send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("burst_relock_63", lk, 1);
    check("burst_err_retained", ec, 8);
    $display("TXN burst last_pos=%0d pulses=%0d err_count=%0d relocked=%0d",
             last, pulses, ec, lk);

    // Asynchronous reset while locked
    #2 rst_n_a = 0;
    #1;
    get_obs(st, lk, ep, ec, bc);
    check("async_rst_state", st, 0); check("async_rst_locked", lk, 0);
    check("async_rst_err_pulse", ep, 0); check("async_rst_err_count", ec, 0);
    check("async_rst_bit_count", bc, 0);
    @(posedge clk);
    #1;
    rst_n_a = 1;
    model_reset();
    repeat (62) send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("rst_relock_62", lk, 0);
    send(1, 0, 0);
    get_obs(st, lk, ep, ec, bc);
    check("rst_relock_63", lk, 1);
    $display("TXN async_reset relocked=%0d", lk);

    // Randomised segments with varying error rates, gaps and clears
    for (int seg = 0; seg < 12; seg++) begin
      case ($urandom_range(3))
        0: rate = 0;
        1: rate = 2;
        2: rate = 10;
        default: rate = 40;
      endcase
      for (int i = 0; i < 200; i++) begin
        send($urandom_range(99) < 80, $urandom_range(99) < rate,
             $urandom_range(99) < 2);
      end
      get_obs(st, lk, ep, ec, bc);
      $display("TXN random seg=%0d rate=%0d state=%0d err_count=%0d bit_count=%0d",
               seg, rate, st, ec, bc);
    end

    // All-zero input from reset
    rst_n_a = 0;
    @(posedge clk);
    #1;
    rst_n_a = 1;
    model_reset();
    saw_locked = 0;
    for (int i = 0; i < 500; i++) begin
      step(1, 0, 0);
      get_obs(st, lk, ep, ec, bc);
      if (st == 2 || lk != 0) saw_locked = 1;
    end
    check("zero_never_locked", saw_locked, 0);
    check("zero_locked", lk, 0);
    check("zero_err_count", ec, 0);
    $display("TXN all_zero state=%0d locked=%0d err_count=%0d", st, lk, ec);

    // Second instance: gaps, saturation, clear with error
    sel = 1;
    rst_n_b = 1;
    model_reset();
    m_thresh = 64; m_err_max = 15;
    cycles = 0;
    for (int c = 1; c <= 300 && cycles == 0; c++) begin
      send((c % 2) == 0, 0, 0);
      get_obs(st, lk, ep, ec, bc);
      if (lk != 0) cycles = c;
    end
    check("gap_lock_cycles", cycles, 126);
    for (int e = 0; e < 20; e++) begin
      for (int k = 0; k < 10; k++) begin
        send(0, 0, 0);
        send(1, k == 9, 0);
      end
    end
    get_obs(st, lk, ep, ec, bc);
    check("sat_err_count", ec, 15);
    check("sat_locked", lk, 1);
    send(0, 0, 0);
    send(1, 1, 1);
    get_obs(st, lk, ep, ec, bc);
    check("clear_err_err_count", ec, 0);
    check("clear_err_pulse", ep, 1);
    check("clear_err_bit_count", bc, 0);
    $display("TXN gaps_sat lock_cycles=%0d err_count=%0d err_pulse=%0d",
             cycles, ec, ep);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
